// File: rtl/register_pkg.sv
`default_nettype none
// ============================================================================
// register_pkg : shared widths and types for the 16x16 register bank
// Optional feature macro: REGISTER_BYPASS_EN (write-through read forwarding)
// Revision     : 1.0
// ============================================================================
package register_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  // Whole storage array as one packed object so it can cross module ports.
  typedef logic [NUM_REGS-1:0][DATA_W-1:0] reg_file_t;

  // True when a write issued this cycle targets the given read address.
  function automatic logic write_hits(input logic      wr_en,
                                      input logic      rst,
                                      input reg_addr_t wr_addr,
                                      input reg_addr_t rd_addr);
    return wr_en && !rst && (wr_addr == rd_addr);
  endfunction

endpackage
`default_nettype wire

// File: rtl/register_if.sv
`default_nettype none
// ============================================================================
// register_if : write port and dual read ports of the register bank
// Revision    : 1.0
// ============================================================================
interface register_if
  import register_pkg::*;
();

  logic      write;
  reg_addr_t WriteAddress;
  reg_data_t WriteData;
  reg_addr_t ReadAddrA;
  reg_addr_t ReadAddrB;
  reg_data_t DataOutputA;
  reg_data_t DataOutputB;

  modport master (
    output write,
    output WriteAddress,
    output WriteData,
    output ReadAddrA,
    output ReadAddrB,
    input  DataOutputA,
    input  DataOutputB
  );

  modport slave (
    input  write,
    input  WriteAddress,
    input  WriteData,
    input  ReadAddrA,
    input  ReadAddrB,
    output DataOutputA,
    output DataOutputB
  );

endinterface
`default_nettype wire

// File: rtl/register_read_port.sv
`default_nettype none
// ============================================================================
// register_read_port : combinational read mux, optional write-through bypass
// Optional feature macro: REGISTER_BYPASS_EN
// Revision           : 1.0
// ============================================================================
module register_read_port
  import register_pkg::*;
(
  input  reg_file_t entries,
  input  reg_addr_t rd_addr,
`ifdef REGISTER_BYPASS_EN
  input  logic      rst,
  input  logic      wr_en,
  input  reg_addr_t wr_addr,
  input  reg_data_t wr_data,
`endif
  output reg_data_t rd_data
);

  reg_data_t stored;

  assign stored = entries[rd_addr];

`ifdef REGISTER_BYPASS_EN
  // Forward the in-flight write so a consumer sees it before the edge.
  always_comb begin
    rd_data = stored;
    if (write_hits(wr_en, rst, wr_addr, rd_addr)) begin
      rd_data = wr_data;
    end
  end
`else
  assign rd_data = stored;
`endif

endmodule
`default_nettype wire

// File: rtl/register.sv
`default_nettype none
// ============================================================================
// register : 16x16 register bank, one synchronous write port, two async reads
// Optional feature macro: REGISTER_BYPASS_EN (write-through read forwarding)
// Revision : 1.0
// ============================================================================
module register
  import register_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  register_if.slave  bus
);

  reg_file_t entries;

  // Reset wins over a coincident write; the write is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      entries <= '0;
    end else if (bus.write) begin
      entries[bus.WriteAddress] <= bus.WriteData;
    end
  end

  register_read_port u_read_a (
    .entries (entries),
    .rd_addr (bus.ReadAddrA),
`ifdef REGISTER_BYPASS_EN
    .rst     (rst),
    .wr_en   (bus.write),
    .wr_addr (bus.WriteAddress),
    .wr_data (bus.WriteData),
`endif
    .rd_data (bus.DataOutputA)
  );

  register_read_port u_read_b (
    .entries (entries),
    .rd_addr (bus.ReadAddrB),
`ifdef REGISTER_BYPASS_EN
    .rst     (rst),
    .wr_en   (bus.write),
    .wr_addr (bus.WriteAddress),
    .wr_data (bus.WriteData),
`endif
    .rd_data (bus.DataOutputB)
  );

endmodule
`default_nettype wire

// File: tb/tb_register.sv
`default_nettype none
// ============================================================================
// tb_register : directed + random self-checking bench for the register bank
// Revision    : 1.0
// ============================================================================
module tb_register;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [15:0] model [16];

  register_if bus ();

  register dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected read value for the current inputs, straight from the behaviour rules.
  function automatic logic [15:0] exp_read(input logic [3:0] addr);
`ifdef REGISTER_BYPASS_EN
    if (bus.write && !rst && bus.WriteAddress == addr) return bus.WriteData;
`endif
    return model[addr];
  endfunction

  // Advance one rising edge, applying the same edge to the reference model.
  task automatic tick();
    if (rst) begin
      for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    end else if (bus.write) begin
      model[bus.WriteAddress] = bus.WriteData;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_ports(input string tag);
    #1;
    chk({tag, "_A"}, bus.DataOutputA, exp_read(bus.ReadAddrA));
    chk({tag, "_B"}, bus.DataOutputB, exp_read(bus.ReadAddrB));
  endtask

  task automatic sweep_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      bus.ReadAddrA = 4'(i);
      bus.ReadAddrB = 4'(15 - i);
      #1;
      chk($sformatf("%s_A%0d", tag, i), bus.DataOutputA, 16'h0000);
      chk($sformatf("%s_B%0d", tag, 15 - i), bus.DataOutputB, 16'h0000);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 16'hxxxx;
    rst              = 1'b1;
    bus.write        = 1'b0;
    bus.WriteAddress = '0;
    bus.WriteData    = '0;
    bus.ReadAddrA    = '0;
    bus.ReadAddrB    = '0;
    @(negedge clk);
    tick();
    rst = 1'b0;
    sweep_zero("por");

    // Arbitrary writes, then a single reset edge must clear everything.
    for (int i = 0; i < 6; i++) begin
      bus.write        = 1'b1;
      bus.WriteAddress = 4'($urandom_range(0, 15));
      bus.WriteData    = 16'($urandom);
      tick();
    end
    bus.write = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sweep_zero("rst");

    // Write entry 5, read on A; stays put across idle edges.
    bus.write = 1'b1; bus.WriteAddress = 4'd5; bus.WriteData = 16'h2025;
    tick();
    bus.write = 1'b0; bus.ReadAddrA = 4'd5;
    #1; chk("wr5_A", bus.DataOutputA, 16'h2025);
    tick(); tick();
    chk("wr5_hold", bus.DataOutputA, 16'h2025);

    // Write entry 1, read on B while A still points at 5.
    bus.write = 1'b1; bus.WriteAddress = 4'd1; bus.WriteData = 16'h5678;
    tick();
    bus.write = 1'b0; bus.ReadAddrB = 4'd1;
    #1;
    chk("wr1_B", bus.DataOutputB, 16'h5678);
    chk("wr1_A5", bus.DataOutputA, 16'h2025);

    // Write disabled: data on the bus must not land.
    bus.write = 1'b0; bus.WriteAddress = 4'd5; bus.WriteData = 16'hFFFF;
    tick(); tick(); tick();
    chk("wdis_A", bus.DataOutputA, 16'h2025);

    // Collision on address 3, both ports reading it.
    bus.write = 1'b1; bus.WriteAddress = 4'd3; bus.WriteData = 16'hABCD;
    bus.ReadAddrA = 4'd3; bus.ReadAddrB = 4'd3;
    #1;
`ifdef REGISTER_BYPASS_EN
    chk("coll_pre_A", bus.DataOutputA, 16'hABCD);
    chk("coll_pre_B", bus.DataOutputB, 16'hABCD);
`else
    chk("coll_pre_A", bus.DataOutputA, 16'h0000);
    chk("coll_pre_B", bus.DataOutputB, 16'h0000);
`endif
    tick();
    bus.write = 1'b0;
    #1;
    chk("coll_post_A", bus.DataOutputA, 16'hABCD);
    chk("coll_post_B", bus.DataOutputB, 16'hABCD);

    // Random traffic with read A tracking the write address; cycle 10 forces reset+write.
    for (int c = 0; c < 20; c++) begin
      bus.write        = 1'($urandom_range(0, 3) != 0);
      bus.WriteAddress = 4'($urandom_range(0, 15));
      bus.WriteData    = 16'($urandom);
      bus.ReadAddrA    = bus.WriteAddress;
      bus.ReadAddrB    = (c % 2 == 0) ? bus.WriteAddress : 4'($urandom_range(0, 15));
      rst              = (c == 10);
      if (c == 10) bus.write = 1'b1;
      check_ports($sformatf("rnd_pre%0d", c));
      tick();
      check_ports($sformatf("rnd_post%0d", c));
      if (c == 10) begin
        rst = 1'b0;
        bus.write = 1'b0;
        sweep_zero("rnd_rst");
      end
    end
    rst = 1'b0;
    bus.write = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/register.md
Name: register

Overview:
- Multi-port register bank for the CPU data path: 16 entries x 16 bits.
- Provides one synchronous write port and two independent combinational read ports (A and B).
- Sits between the write-back 2:1 mux, which supplies WriteData, and the ALU operand inputs, which consume DataOutputA/B.
- Synchronous active-high reset clears every entry.

Parameters:
- DATA_W, 16, width of each register and of the data ports.
- ADDR_W, 4, address width; number of entries is 2**ADDR_W (16).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous reset, active-high.
- write  input  1  write enable; when high, a write occurs on the rising edge.
- WriteAddress  input  ADDR_W  entry selected for writing.
- WriteData  input  DATA_W  data written to the selected entry.
- ReadAddrA  input  ADDR_W  A-side read address.
- ReadAddrB  input  ADDR_W  B-side read address.
- DataOutputA  output  DATA_W  contents of entry ReadAddrA.
- DataOutputB  output  DATA_W  contents of entry ReadAddrB.

Behaviour:
- Storage: array of 2**ADDR_W registers, each DATA_W wide. All entries are general purpose; none is hardwired.
- Reset:
  - On a rising edge with rst=1, all entries become 0. DataOutputA and DataOutputB therefore read 0 after that edge.
  - rst has priority over write; a write in the same cycle is dropped.
- Write:
  - On a rising edge with rst=0 and write=1, entry[WriteAddress] <= WriteData.
  - Latency is one edge. No other entry changes.
  - With write=0, nothing changes.
- Read:
  - Purely combinational: DataOutputA = entry[ReadAddrA], DataOutputB = entry[ReadAddrB].
  - Outputs update immediately on any address change or on a storage update. There is no read latency.
- Same address on both read ports: both outputs show identical data.
- Read/write collision (macro absent): reading the address being written shows the old value until the clock edge, then the new value.
- All addresses 0..15 are valid; there is no out-of-range condition.
- Reset mid-operation: a pending write is discarded, and reads return 0 from the edge onward.
- There is no handshake; write is single-cycle and may be held high for back-to-back writes, one per edge.

Optional Feature:
- Macro REGISTER_BYPASS_EN.
- Defined: write-through forwarding. When write=1 and rst=0, any read port whose address equals WriteAddress outputs WriteData combinationally in the same cycle, before the edge. Each port is checked independently.
- Undefined: no forwarding; reads always return stored contents.
- Storage and reset behaviour are identical in both builds.

Decomposition:
- Package register_pkg holds:
  - localparams DATA_W=16, ADDR_W=4, NUM_REGS=16;
  - typedefs reg_data_t (logic [DATA_W-1:0]) and reg_addr_t (logic [ADDR_W-1:0]).
- Sub-module register_read_port: combinational read mux with the optional bypass compare. It takes the storage array, the read address, and write/WriteAddress/WriteData, and is instantiated twice (A and B).

Test Plan:
- Reset: assert rst for one edge after arbitrary writes -> every address reads 0000 on both ports.
- Write and read A: write=1, WriteAddress=5, WriteData=2025 for one edge; then write=0, ReadAddrA=5 -> DataOutputA=2025, and entry 5 unchanged on later edges.
- Write and read B: write=1, WriteAddress=1, WriteData=5678 for one edge; then ReadAddrB=1 -> DataOutputB=5678, and ReadAddrA=5 still gives 2025.
- Write disabled: write=0, WriteAddress=5, WriteData=FFFF over several edges -> entry 5 stays 2025.
- Collision: write=1, WriteAddress=3, WriteData=ABCD, ReadAddrA=ReadAddrB=3.
  - Before the edge: old value (macro off) or ABCD (REGISTER_BYPASS_EN on).
  - After the edge: ABCD on both ports.
- Random: 20 cycles of random {write, WriteAddress, WriteData} with ReadAddrA/B tracking WriteAddress, checked against a reference array model; include rst=1 together with write=1, where the write must be dropped and all entries read 0.
